// File: rtl/chip_despreader.sv
// Chip despreader: collects 32-chip words, picks the nearest of 16 reference sequences.
// Optional saturating error counter port enabled by CHIP_DESPREADER_ERRCNT_EN.
module chip_despreader #(
  parameter int MAX_DIST = 10
) (
  input  logic       inClock,
  input  logic       inReset,
  input  logic       inChip,
  input  logic       inChipValid,
  input  logic       inSync,
  input  logic       inSymbolReady,
  output logic [3:0] outSymbol,
  output logic       outSymbolValid,
  output logic       outSymbolError,
  output logic       outOverrun,
`ifdef CHIP_DESPREADER_ERRCNT_EN
  output logic [7:0] outErrorCount,
`endif
  output logic       outBusy
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SEARCH  = 2'd1,
    OUTPUT  = 2'd2
  } stateType;

  // Reference S0 written as received: bit 31 of the literal is chip 0.
  localparam logic [31:0] S0_TEXT = 32'b11011001110000110101001000101110;

  function automatic logic [31:0] refSeq(input logic [3:0] k);
    logic [31:0] seq;
    logic [4:0]  src;
    seq = '0;
    for (int i = 0; i < 32; i++) begin
      src    = 5'(i) - {k[2:0], 2'b00};
      seq[i] = S0_TEXT[5'd31 - src];
    end
    if (k[3]) seq = seq ^ 32'hAAAA_AAAA;
    return seq;
  endfunction

  function automatic logic [5:0] popCount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'd0, v[i]};
    return c;
  endfunction

  stateType    state_q, state_d;
  logic [4:0]  chipCount_q, chipCount_d;
  logic [31:0] word_q, word_d;
  logic [31:0] hold_q, hold_d;
  logic [3:0]  searchIdx_q, searchIdx_d;
  logic [5:0]  dist_q, dist_d;
  logic [3:0]  distK_q, distK_d;
  logic        distValid_q, distValid_d;
  logic [5:0]  bestDist_q, bestDist_d;
  logic [3:0]  bestK_q, bestK_d;
  logic [3:0]  symbol_q, symbol_d;
  logic        symValid_q, symValid_d;
  logic        symErr_q, symErr_d;
  logic        overrun_q, overrun_d;
`ifdef CHIP_DESPREADER_ERRCNT_EN
  logic [7:0]  errCount_q, errCount_d;
`endif

  logic [4:0] chipIdx;
  logic       wordDone;
  logic       holdLoad;
  logic       takeNew;
  logic       accepted;

  always_comb begin
    state_d     = state_q;
    chipCount_d = chipCount_q;
    word_d      = word_q;
    hold_d      = hold_q;
    searchIdx_d = searchIdx_q;
    dist_d      = dist_q;
    distK_d     = distK_q;
    distValid_d = 1'b0;
    bestDist_d  = bestDist_q;
    bestK_d     = bestK_q;
    symbol_d    = symbol_q;
    symValid_d  = symValid_q;
    symErr_d    = symErr_q;
    overrun_d   = 1'b0;
`ifdef CHIP_DESPREADER_ERRCNT_EN
    errCount_d  = errCount_q;
`endif
    chipIdx  = inSync ? 5'd0 : chipCount_q;
    wordDone = inChipValid && !inSync && (chipCount_q == 5'd31);
    holdLoad = wordDone && (state_q == COLLECT);
    accepted = symValid_q && inSymbolReady;

    // Sync throws away the partial word; a chip arriving with it becomes chip 0.
    if (inSync) begin
      word_d      = '0;
      chipCount_d = '0;
    end
    if (inChipValid) begin
      word_d[chipIdx] = inChip;
      chipCount_d     = chipIdx + 5'd1;
    end
    if (holdLoad) hold_d = word_d;
    overrun_d = wordDone && (state_q != COLLECT);

    case (state_q)
      COLLECT: if (holdLoad) begin
        state_d     = SEARCH;
        searchIdx_d = '0;
      end
      SEARCH: begin
        searchIdx_d = searchIdx_q + 4'd1;
        if (searchIdx_q == 4'd15) state_d = OUTPUT;
      end
      OUTPUT: if (accepted) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase

    // Distance is registered one cycle before the running-minimum compare.
    if (state_q == SEARCH) begin
      dist_d      = popCount(hold_q ^ refSeq(searchIdx_q));
      distK_d     = searchIdx_q;
      distValid_d = 1'b1;
    end
    takeNew = distValid_q && ((distK_q == 4'd0) || (dist_q < bestDist_q));
    if (takeNew) begin
      bestDist_d = dist_q;
      bestK_d    = distK_q;
    end

    if (accepted) symValid_d = 1'b0;
    if (distValid_q && (distK_q == 4'd15)) begin
      symValid_d = 1'b1;
      symbol_d   = bestK_d;
      symErr_d   = int'(bestDist_d) > MAX_DIST;
    end
`ifdef CHIP_DESPREADER_ERRCNT_EN
    if (accepted && symErr_q && (errCount_q != 8'hFF)) errCount_d = errCount_q + 8'd1;
`endif
  end

  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      state_q     <= COLLECT;
      chipCount_q <= '0;
      word_q      <= '0;
      hold_q      <= '0;
      searchIdx_q <= '0;
      dist_q      <= '0;
      distK_q     <= '0;
      distValid_q <= 1'b0;
      bestDist_q  <= '0;
      bestK_q     <= '0;
      symbol_q    <= '0;
      symValid_q  <= 1'b0;
      symErr_q    <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef CHIP_DESPREADER_ERRCNT_EN
      errCount_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      chipCount_q <= chipCount_d;
      word_q      <= word_d;
      hold_q      <= hold_d;
      searchIdx_q <= searchIdx_d;
      dist_q      <= dist_d;
      distK_q     <= distK_d;
      distValid_q <= distValid_d;
      bestDist_q  <= bestDist_d;
      bestK_q     <= bestK_d;
      symbol_q    <= symbol_d;
      symValid_q  <= symValid_d;
      symErr_q    <= symErr_d;
      overrun_q   <= overrun_d;
`ifdef CHIP_DESPREADER_ERRCNT_EN
      errCount_q  <= errCount_d;
`endif
    end
  end

  assign outSymbol      = symbol_q;
  assign outSymbolValid = symValid_q;
  assign outSymbolError = symErr_q;
  assign outOverrun     = overrun_q;
  assign outBusy        = (state_q != COLLECT);
`ifdef CHIP_DESPREADER_ERRCNT_EN
  assign outErrorCount  = errCount_q;
`endif

endmodule

// File: tb/tb_chip_despreader.sv
// Directed testbench for chip_despreader: reference words, noisy words, backpressure,
// resync and mid-search reset, with symbols collected as they are accepted.
module tb_chip_despreader;

  logic       inClock;
  logic       inReset;
  logic       inChip;
  logic       inChipValid;
  logic       inSync;
  logic       inSymbolReady;
  logic [3:0] outSymbol;
  logic       outSymbolValid;
  logic       outSymbolError;
  logic       outOverrun;
  logic       outBusy;
`ifdef CHIP_DESPREADER_ERRCNT_EN
  logic [7:0] outErrorCount;
`endif

  int checks   = 0;
  int failures = 0;
  int overruns = 0;
  logic [4:0] accQ[$];

  chip_despreader #(.MAX_DIST(10)) dut (
    .inClock       (inClock),
    .inReset       (inReset),
    .inChip        (inChip),
    .inChipValid   (inChipValid),
    .inSync        (inSync),
    .inSymbolReady (inSymbolReady),
    .outSymbol     (outSymbol),
    .outSymbolValid(outSymbolValid),
    .outSymbolError(outSymbolError),
    .outOverrun    (outOverrun),
`ifdef CHIP_DESPREADER_ERRCNT_EN
    .outErrorCount (outErrorCount),
`endif
    .outBusy       (outBusy)
  );

  initial inClock = 1'b0;
  always #5 inClock = ~inClock;

  localparam logic [31:0] S0_MSB_FIRST = 32'b11011001110000110101001000101110;

  // Bit i of the returned word is the chip sent i-th.
  function automatic logic [31:0] seqOf(input int k);
    logic [31:0] s;
    int src;
    for (int i = 0; i < 32; i++) begin
      src  = (i - 4 * (k % 8) + 64) % 32;
      s[i] = S0_MSB_FIRST[31 - src];
      if (k >= 8 && (i % 2) == 1) s[i] = ~s[i];
    end
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs are final when this is called, so an accepted symbol is logged before the edge.
  task automatic stepCycle();
    if (outSymbolValid && inSymbolReady) accQ.push_back({outSymbolError, outSymbol});
    @(posedge inClock);
    #1;
    if (outOverrun) overruns++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic applyStimulus(input logic [31:0] w, input int nChips, input bit syncFirst);
    for (int i = 0; i < nChips; i++) begin
      inChip      = w[i];
      inChipValid = 1'b1;
      inSync      = syncFirst && (i == 0);
      stepCycle();
    end
    inChip      = 1'b0;
    inChipValid = 1'b0;
    inSync      = 1'b0;
  endtask

  task automatic checkQueue(input string tag, input int idx, input logic [4:0] expected);
    logic [31:0] got;
    got = (idx < accQ.size()) ? {27'd0, accQ[idx]} : 32'hFFFF_FFFF;
    checkOutput(tag, got, {27'd0, expected});
  endtask

  initial begin
    int n;
    inReset       = 1'b0;
    inChip        = 1'b0;
    inChipValid   = 1'b0;
    inSync        = 1'b0;
    inSymbolReady = 1'b1;
    idle(2);
    checkOutput("rst_symbol", outSymbol, 0);
    checkOutput("rst_valid", outSymbolValid, 0);
    checkOutput("rst_error", outSymbolError, 0);
    checkOutput("rst_overrun", outOverrun, 0);
    checkOutput("rst_busy", outBusy, 0);
`ifdef CHIP_DESPREADER_ERRCNT_EN
    checkOutput("rst_errcount", outErrorCount, 0);
`endif
    inReset = 1'b1;
    idle(2);

    $display("[TB] single S5 word");
    applyStimulus(seqOf(5), 32, 1'b0);
    checkOutput("s5_busy", outBusy, 1);
    n = 0;
    while (!outSymbolValid && n < 40) begin
      stepCycle();
      n++;
    end
    checkOutput("s5_latency", n, 17);
    checkOutput("s5_symbol", outSymbol, 5);
    checkOutput("s5_error", outSymbolError, 0);
    stepCycle();
    checkOutput("s5_valid_drop", outSymbolValid, 0);
    checkOutput("s5_busy_drop", outBusy, 0);
    checkQueue("s5_accepted", 0, 5'h05);

    $display("[TB] all sixteen sequences back to back");
    accQ.delete();
    overruns = 0;
    for (int k = 0; k < 16; k++) applyStimulus(seqOf(k), 32, 1'b0);
    idle(20);
    checkOutput("seq16_count", accQ.size(), 16);
    for (int k = 0; k < 16; k++) checkQueue($sformatf("seq16_sym%0d", k), k, 5'(k));
    checkOutput("seq16_overrun", overruns, 0);

    $display("[TB] noisy S9 words");
    accQ.delete();
    applyStimulus(seqOf(9) ^ 32'hA000_FF00, 32, 1'b0);
    idle(20);
    checkQueue("s9_flip10", 0, 5'h09);
    applyStimulus(seqOf(9) ^ 32'h5555_5555, 32, 1'b0);
    idle(20);
    checkOutput("s9_flip16_count", accQ.size(), 2);
    checkOutput("s9_flip16_error", (accQ.size() > 1) ? {31'd0, accQ[1][4]} : 32'hFFFF_FFFF, 1);
`ifdef CHIP_DESPREADER_ERRCNT_EN
    checkOutput("s9_errcount", outErrorCount, 1);
`endif

    $display("[TB] backpressure with two dropped words");
    accQ.delete();
    overruns = 0;
    inSymbolReady = 1'b0;
    applyStimulus(seqOf(2), 32, 1'b0);
    applyStimulus(seqOf(4), 32, 1'b0);
    applyStimulus(seqOf(6), 32, 1'b0);
    checkOutput("bp_valid", outSymbolValid, 1);
    checkOutput("bp_symbol", outSymbol, 2);
    checkOutput("bp_overruns", overruns, 2);
    checkOutput("bp_none_yet", accQ.size(), 0);
    inSymbolReady = 1'b1;
    stepCycle();
    idle(20);
    checkOutput("bp_count", accQ.size(), 1);
    checkQueue("bp_first", 0, 5'h02);

    $display("[TB] resync discards partial words");
    accQ.delete();
    applyStimulus(seqOf(11), 13, 1'b0);
    inSync = 1'b1;
    stepCycle();
    inSync = 1'b0;
    applyStimulus(seqOf(3), 32, 1'b0);
    applyStimulus(seqOf(5), 7, 1'b0);
    applyStimulus(seqOf(12), 32, 1'b1);
    idle(20);
    checkOutput("sync_count", accQ.size(), 2);
    checkQueue("sync_s3", 0, 5'h03);
    checkQueue("sync_s12", 1, 5'h0C);

    $display("[TB] reset during search");
    accQ.delete();
    overruns = 0;
    applyStimulus(seqOf(1), 32, 1'b0);
    idle(5);
    checkOutput("mid_busy", outBusy, 1);
    inReset = 1'b0;
    #1;
    checkOutput("mid_rst_busy", outBusy, 0);
    checkOutput("mid_rst_valid", outSymbolValid, 0);
    checkOutput("mid_rst_symbol", outSymbol, 0);
    checkOutput("mid_rst_error", outSymbolError, 0);
`ifdef CHIP_DESPREADER_ERRCNT_EN
    checkOutput("mid_rst_errcount", outErrorCount, 0);
`endif
    idle(2);
    inReset = 1'b1;
    stepCycle();
    applyStimulus(seqOf(7), 32, 1'b0);
    idle(20);
    checkOutput("post_rst_count", accQ.size(), 1);
    checkQueue("post_rst_s7", 0, 5'h07);
    checkOutput("post_rst_overrun", overruns, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chip_despreader.md
CHIP_DESPREADER -- requirements
Module: chip_despreader

Interface
REQ-001 SHALL have parameter MAX_DIST, default 10, meaning the maximum Hamming distance accepted as an error-free symbol decision.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port inClock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port inReset, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port inChip, input, 1 bit: received chip value.
REQ-006 SHALL have port inChipValid, input, 1 bit: inChip is valid this cycle.
REQ-007 SHALL have port inSync, input, 1 bit: synchronous symbol-boundary realign.
REQ-008 SHALL have port inSymbolReady, input, 1 bit: downstream (outFIFO not full) accepts a symbol.
REQ-009 SHALL have port outSymbol, output, 4 bits: decoded symbol.
REQ-010 SHALL have port outSymbolValid, output, 1 bit: outSymbol and outSymbolError are valid.
REQ-011 SHALL have port outSymbolError, output, 1 bit: best distance > MAX_DIST.
REQ-012 SHALL have port outOverrun, output, 1 bit: one-cycle pulse when a completed chip word is dropped.
REQ-013 SHALL have port outBusy, output, 1 bit: high in SEARCH or OUTPUT state.

Function
REQ-014 SHALL use reference sequence S0 = 11011001110000110101001000101110, with c0 leftmost and received first.
REQ-015 SHALL define Sk for k=1..7 by Sk[i] = S0[(i-4k) mod 32].
REQ-016 SHALL define Sk+8 = Sk with odd-index chips inverted.
REQ-017 SHALL store each chip accepted with inChipValid=1 at index = chip counter (0..31); the counter increments and wraps 31->0.
REQ-018 SHALL copy the 32-chip word to a hold register on the edge accepting chip 31, when the FSM is in COLLECT; collection of the next word continues without gaps.
REQ-019 SHALL implement FSM states COLLECT, SEARCH, OUTPUT. COLLECT->SEARCH on hold load; SEARCH lasts exactly 16 cycles; SEARCH->OUTPUT; OUTPUT->COLLECT on the cycle where outSymbolValid and inSymbolReady are both 1.
REQ-020 SHALL evaluate candidate k in SEARCH cycle k (k=0..15): distance = popcount(hold XOR Sk), 6-bit result.
REQ-021 SHALL keep the minimum distance; on a tie the lowest k wins.
REQ-022 SHALL assert outSymbolValid exactly 17 cycles after the edge that captured chip 31, holding outSymbol and outSymbolError stable until accepted.
REQ-023 SHALL, when chip 31 completes while the FSM is not in COLLECT, drop that word, pulse outOverrun for 1 cycle, and leave the pending result unaffected.
REQ-024 SHALL, on inSync=1, clear the chip counter and discard the partial word; if inChipValid=1 in the same cycle, that chip becomes chip 0.
REQ-025 SHALL NOT let inSync abort SEARCH or OUTPUT.
REQ-026 SHALL accept inChipValid in every cycle; there is no backpressure on chip input.

Reset
REQ-027 SHALL, on inReset=0, immediately set FSM=COLLECT, chip counter=0, shift/hold registers=0, and all outputs to 0 (outSymbol=4'h0).
REQ-028 SHALL, on reset mid-SEARCH or mid-OUTPUT, lose the pending symbol without asserting outOverrun.

Configuration
REQ-029 SHALL, with macro CHIP_DESPREADER_ERRCNT_EN defined, add output outErrorCount (8 bits, reset 0) that increments on each accepted symbol with outSymbolError=1 and saturates at 255.
REQ-030 SHALL, without CHIP_DESPREADER_ERRCNT_EN, omit the port and its logic; all other behaviour is identical.

Verification
REQ-031 SHALL cover: 32 chips of S5, valid every cycle, inSymbolReady=1 -> outSymbol=4'h5, outSymbolError=0, outSymbolValid 17 cycles after chip 31.
REQ-032 SHALL cover: all 16 Sk sent back-to-back -> symbols 0..15 in order, no overrun.
REQ-033 SHALL cover: S9 with 10 chips flipped -> 4'h9, error=0; S9 with 16 chips flipped -> error=1 and errcount+1 (macro on).
REQ-034 SHALL cover: inSymbolReady=0 held through 2 further words -> first symbol held, outOverrun pulses once per dropped word, first symbol delivered on ready.
REQ-035 SHALL cover: inSync after 13 chips, then S3 -> 4'h3 only; partial word never output.
REQ-036 SHALL cover: inReset=0 during SEARCH -> outputs 0 immediately, next full S7 decodes as 4'h7.
